// File: rtl/eth_rx_frame_writer.sv
// Writes MAC RX AXI-Stream frames into a word-addressed ring buffer and emits one
// descriptor per good frame; bad, oversize or overflowing frames are rewound and counted.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// RECV  | writing beats of a frame into the ring
// DROP  | discarding the rest of a bad frame until tlast
// DESC  | holding the descriptor until desc_ready
module eth_rx_frame_writer #(
   parameter int DATA_WIDTH      = 64,
   parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH      = 12,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_FRAME_BYTES = 9216
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  buf_wr_en,
   output logic [ADDR_WIDTH-1:0] buf_wr_addr,
   output logic [DATA_WIDTH-1:0] buf_wr_data,
   output logic [KEEP_WIDTH-1:0] buf_wr_strb,
   input  logic [ADDR_WIDTH-1:0] buf_rd_ptr,
   output logic                  desc_valid,
   input  logic                  desc_ready,
   output logic [ADDR_WIDTH-1:0] desc_start,
   output logic [LEN_WIDTH-1:0]  desc_len,
   output logic [15:0]           drop_count
);

   localparam int CNT_W = LEN_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RECV, DROP, DESC} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] frame_start;
   logic [CNT_W-1:0]      byte_cnt;

   logic [CNT_W-1:0]      beat_len;
   logic [CNT_W-1:0]      new_cnt;
   logic [ADDR_WIDTH-1:0] free_words;
   logic [ADDR_WIDTH-1:0] start_cur;
   logic                  accept;
   logic                  beat_ok;
   logic                  drop_exit;

   always_comb begin
      beat_len = '0;
      if (s_axis_tlast) begin
         for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_len = beat_len + CNT_W'(s_axis_tkeep[i]);
         end
      end else begin
         beat_len = CNT_W'(KEEP_WIDTH);
      end
      new_cnt    = byte_cnt + beat_len;
      free_words = buf_rd_ptr - wr_ptr - ADDR_WIDTH'(1);
      beat_ok    = (free_words != '0) && (new_cnt <= CNT_W'(MAX_FRAME_BYTES));
      accept     = s_axis_tvalid && s_axis_tready;
      // frame_start is only loaded on the first beat, so IDLE uses wr_ptr directly
      start_cur  = (state == IDLE) ? wr_ptr : frame_start;
      drop_exit  = 1'b0;
      if (accept && s_axis_tlast) begin
         case (state)
            IDLE, RECV: drop_exit = !beat_ok || s_axis_tuser;
            DROP:       drop_exit = 1'b1;
            default:    drop_exit = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         frame_start   <= '0;
         byte_cnt      <= '0;
         s_axis_tready <= 1'b0;
         buf_wr_en     <= 1'b0;
         buf_wr_addr   <= '0;
         buf_wr_data   <= '0;
         buf_wr_strb   <= '0;
         desc_valid    <= 1'b0;
         desc_start    <= '0;
         desc_len      <= '0;
         drop_count    <= '0;
      end else begin
         buf_wr_en <= 1'b0;
         if (state != DESC) s_axis_tready <= 1'b1;
         case (state)
            IDLE, RECV: begin
               if (accept) begin
                  if (state == IDLE) frame_start <= wr_ptr;
                  if (!beat_ok) begin
                     state <= DROP;
                  end else begin
                     buf_wr_en   <= 1'b1;
                     buf_wr_addr <= wr_ptr;
                     buf_wr_data <= s_axis_tdata;
                     buf_wr_strb <= s_axis_tkeep;
                     wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
                     byte_cnt    <= new_cnt;
                     if (s_axis_tlast && !s_axis_tuser) begin
                        desc_valid    <= 1'b1;
                        desc_start    <= start_cur;
                        desc_len      <= new_cnt[LEN_WIDTH-1:0];
                        s_axis_tready <= 1'b0;
                        state         <= DESC;
                     end else begin
                        state <= RECV;
                     end
                  end
               end
            end
            DROP: begin
            end
            DESC: begin
               if (desc_ready) begin
                  desc_valid    <= 1'b0;
                  byte_cnt      <= '0;
                  s_axis_tready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // rewind overrides any pointer advance made by the same beat
         if (drop_exit) begin
            wr_ptr   <= start_cur;
            byte_cnt <= '0;
            state    <= IDLE;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Bench for eth_rx_frame_writer: frame-level ring model predicts every RAM write,
// descriptor and drop count; directed frames pin the model with literal values.
module tb_eth_rx_frame_writer;

   localparam int RING = 4096;
   localparam int MAXB = 9216;

   logic        clock;
   logic        resetn;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic        buf_wr_en;
   logic [11:0] buf_wr_addr;
   logic [63:0] buf_wr_data;
   logic [7:0]  buf_wr_strb;
   logic [11:0] rd_ptr;
   logic        desc_valid;
   logic        desc_ready;
   logic [11:0] desc_start;
   logic [15:0] desc_len;
   logic [15:0] drop_count;

   eth_rx_frame_writer dut (
      .clock(clock), .resetn(resetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
      .buf_wr_data(buf_wr_data), .buf_wr_strb(buf_wr_strb),
      .buf_rd_ptr(rd_ptr),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_start(desc_start), .desc_len(desc_len),
      .drop_count(drop_count)
   );

   typedef struct packed {
      logic [11:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } wr_t;

   typedef struct packed {
      logic [11:0] start;
      logic [15:0] len;
   } desc_t;

   wr_t   exp_wr[$];
   desc_t exp_desc[$];
   int    m_wp;
   int    m_drops;
   int    n_checks;
   int    n_pass;
   int    ready_mode;
   bit    gap_en;

   initial clock = 1'b0;
   always #4 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // descriptor consumer: 0 = hold low, 1 = random, 2 = always ready
   initial begin
      desc_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       desc_ready = 1'b0;
            1:       desc_ready = 1'($urandom_range(0, 1));
            default: desc_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clock) begin
      if (resetn) begin
         if (buf_wr_en) begin
            chk("wr_pending", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("wr_addr", 64'(buf_wr_addr), 64'(w.addr));
               chk("wr_data", buf_wr_data, w.data);
               chk("wr_strb", 64'(buf_wr_strb), 64'(w.strb));
            end
         end
         if (desc_valid) begin
            chk("desc_pending", 64'(exp_desc.size() > 0), 64'd1);
            chk("tready_in_desc", 64'(s_axis_tready), 64'd0);
            if (exp_desc.size() > 0) begin
               chk("desc_start", 64'(desc_start), 64'(exp_desc[0].start));
               chk("desc_len", 64'(desc_len), 64'(exp_desc[0].len));
               if (desc_ready) void'(exp_desc.pop_front());
            end
         end
      end
   end

   task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input bit last, input bit user);
      int guard = 0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = last;
      s_axis_tuser  = user;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && guard < 500) begin
         @(negedge clock);
         guard++;
      end
      chk("beat_accept", 64'(s_axis_tready), 64'd1);
      @(negedge clock);
      s_axis_tvalid = 1'b0;
   endtask

   // model: beat k is refused when the ring is full (k == initial free space)
   // or the running byte count passes MAXB; earlier beats are written
   task automatic send_frame(input int n, input logic [7:0] lastkeep, input bit user,
                             input int rd, input int stop_at);
      int          free_w, total, m, cum, sent;
      bit          good;
      logic [63:0] d[];
      rd_ptr = 12'(rd);
      free_w = ((rd - m_wp - 1) % RING + RING) % RING;
      total  = 8 * (n - 1) + $countones(lastkeep);
      m      = n;
      cum    = 0;
      for (int k = 0; k < n; k++) begin
         cum += (k == n - 1) ? $countones(lastkeep) : 8;
         if (k == free_w || cum > MAXB) begin
            m = k;
            break;
         end
      end
      good = (m == n) && !user;
      sent = (stop_at < n) ? stop_at : n;
      d = new[n];
      for (int k = 0; k < n; k++) d[k] = {$urandom, $urandom};
      for (int k = 0; k < sent && k < m; k++)
         exp_wr.push_back('{addr: 12'((m_wp + k) % RING), data: d[k],
                            strb: (k == n - 1) ? lastkeep : 8'hFF});
      if (sent == n) begin
         if (good) begin
            exp_desc.push_back('{start: 12'(m_wp), len: 16'(total)});
            m_wp = (m_wp + n) % RING;
         end else if (m_drops < 65535) begin
            m_drops++;
         end
      end
      for (int k = 0; k < sent; k++) begin
         if (gap_en && $urandom_range(0, 3) == 0) @(negedge clock);
         if (k == n - 1) drive_beat(d[k], lastkeep, 1'b1, user);
         else            drive_beat(d[k], 8'hFF, 1'b0, 1'($urandom_range(0, 1)));
      end
      if (sent == n) begin
         chk("desc_after_tlast", 64'(desc_valid), 64'(good));
         if (good) chk("last_write_visible", 64'(buf_wr_en), 64'd1);
         chk("drop_count", 64'(drop_count), 64'(m_drops));
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_wr_en", 64'(buf_wr_en), 64'd0);
      chk("rst_wr_addr", 64'(buf_wr_addr), 64'd0);
      chk("rst_wr_data", buf_wr_data, 64'd0);
      chk("rst_wr_strb", 64'(buf_wr_strb), 64'd0);
      chk("rst_desc_valid", 64'(desc_valid), 64'd0);
      chk("rst_desc_start", 64'(desc_start), 64'd0);
      chk("rst_desc_len", 64'(desc_len), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
   endtask

   task automatic do_reset();
      #2 resetn = 1'b0;
      #1 check_reset_outputs();
      exp_wr.delete();
      exp_desc.delete();
      m_wp    = 0;
      m_drops = 0;
      @(negedge clock);
      #2 resetn = 1'b1;
      @(negedge clock);
      chk("tready_after_reset", 64'(s_axis_tready), 64'd1);
   endtask

   initial begin
      int d0, n, k, free_w;
      n_checks = 0; n_pass = 0; m_wp = 0; m_drops = 0;
      ready_mode = 1; gap_en = 1'b0;
      resetn = 1'b0; rd_ptr = '0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
      #1 check_reset_outputs();
      @(negedge clock);
      @(negedge clock);
      #2 resetn = 1'b1;
      @(negedge clock);
      chk("tready_after_reset", 64'(s_axis_tready), 64'd1);

      send_frame(8, 8'hFF, 1'b0, 0, 1 << 30);
      chk("f64_start", 64'(desc_start), 64'd0);
      chk("f64_len", 64'(desc_len), 64'd64);
      chk("f64_last_addr", 64'(buf_wr_addr), 64'd7);

      send_frame(8, 8'h1F, 1'b0, 0, 1 << 30);
      chk("f61_start", 64'(desc_start), 64'd8);
      chk("f61_len", 64'(desc_len), 64'd61);
      chk("f61_last_strb", 64'(buf_wr_strb), 64'h1F);

      send_frame(16, 8'hFF, 1'b1, 0, 1 << 30);
      chk("tuser_drop_count", 64'(drop_count), 64'd1);

      ready_mode = 0;
      send_frame(2, 8'hFF, 1'b0, 0, 1 << 30);
      chk("after_drop_start", 64'(desc_start), 64'd16);
      fork
         send_frame(3, 8'h0F, 1'b0, 0, 1 << 30);
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clock);
               chk("hold_tready", 64'(s_axis_tready), 64'd0);
               chk("hold_start", 64'(desc_start), 64'd16);
               chk("hold_len", 64'(desc_len), 64'd16);
            end
            ready_mode = 1;
         end
      join

      gap_en = 1'b1;
      for (int f = 0; f < 150; f++) begin
         n = $urandom_range(1, 16);
         k = $urandom_range(1, 8);
         free_w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(13, 4000);
         send_frame(n, 8'((1 << k) - 1), ($urandom_range(0, 9) == 0),
                    (m_wp + 1 + free_w) % RING, 1 << 30);
      end
      gap_en = 1'b0;

      d0 = m_drops;
      send_frame(1153, 8'hFF, 1'b0, m_wp, 1 << 30);
      chk("oversize_drop", 64'(drop_count), 64'(d0 + 1));
      send_frame(1152, 8'hFF, 1'b0, m_wp, 1 << 30);
      chk("max_len", 64'(desc_len), 64'd9216);

      send_frame(5, 8'hFF, 1'b0, m_wp, 3);
      do_reset();
      send_frame(2, 8'h07, 1'b0, 0, 1 << 30);
      chk("post_reset_start", 64'(desc_start), 64'd0);
      chk("post_reset_len", 64'(desc_len), 64'd11);

      send_frame(1023, 8'hFF, 1'b0, m_wp, 1 << 30);
      send_frame(1023, 8'hFF, 1'b0, m_wp, 1 << 30);
      send_frame(1023, 8'hFF, 1'b0, m_wp, 1 << 30);
      send_frame(1021, 8'hFF, 1'b0, m_wp, 1 << 30);
      send_frame(8, 8'hFF, 1'b0, 4095, 1 << 30);
      chk("full_ring_drop", 64'(drop_count), 64'd1);
      send_frame(8, 8'hFF, 1'b0, 100, 1 << 30);
      chk("wrap_start", 64'(desc_start), 64'd4092);
      chk("wrap_len", 64'(desc_len), 64'd64);
      chk("wrap_last_addr", 64'(buf_wr_addr), 64'd3);

      ready_mode = 2;
      for (int i = 0; i < 100 && (exp_desc.size() != 0 || desc_valid); i++) @(negedge clock);
      chk("desc_drained", 64'(exp_desc.size()), 64'd0);
      chk("writes_drained", 64'(exp_wr.size()), 64'd0);
      chk("final_drop_count", 64'(drop_count), 64'(m_drops));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame_writer.md
# eth_rx_frame_writer

Receive-side consumer of the 64-bit Ethernet MAC RX AXI-Stream (the `eth0_rx_axis_*` output of the QSFP/10G MAC wrapper). It writes each received frame into a word-addressed ring buffer RAM through a simple write port and publishes one descriptor per good frame via a valid/ready handshake. Bad frames (tuser error, oversize, or ring overflow) are rewound and counted, and produce no descriptor. The block sits between the MAC FIFO and the DMA/descriptor logic, in the MAC logic clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 64: stream and RAM word width, in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep and strobe width.
- `ADDR_WIDTH`, 12: ring word-address width. The ring holds 2^ADDR_WIDTH words.
- `LEN_WIDTH`, 16: width of the descriptor length field, in bytes.
- `MAX_FRAME_BYTES`, 9216: largest accepted frame length.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `s_axis_tdata`, in, DATA_WIDTH: RX data.
- `s_axis_tkeep`, in, KEEP_WIDTH: byte enables. Contiguous from the LSB, and all ones except on the tlast beat.
- `s_axis_tvalid`, in, 1: RX beat valid.
- `s_axis_tready`, out, 1: RX beat ready.
- `s_axis_tlast`, in, 1: last beat of a frame.
- `s_axis_tuser`, in, 1: bad-frame flag. Sampled only on the tlast beat.
- `buf_wr_en`, out, 1: RAM write strobe.
- `buf_wr_addr`, out, ADDR_WIDTH: RAM word address.
- `buf_wr_data`, out, DATA_WIDTH: RAM write data.
- `buf_wr_strb`, out, KEEP_WIDTH: RAM byte strobes (equal to the beat's tkeep).
- `buf_rd_ptr`, in, ADDR_WIDTH: consumer's free pointer. It is the first word not yet released.
- `desc_valid`, out, 1: descriptor valid.
- `desc_ready`, in, 1: descriptor ready.
- `desc_start`, out, ADDR_WIDTH: word address of the frame's first beat.
- `desc_len`, out, LEN_WIDTH: frame length in bytes.
- `drop_count`, out, 16: dropped-frame counter. Saturates at 0xFFFF.

## Operation
Internal registers:
- `wr_ptr`: next write address.
- `frame_start`: committed start address of the current frame.
- `byte_cnt`: running byte count.

Free space is `(buf_rd_ptr - wr_ptr - 1) mod 2^ADDR_WIDTH` words. The ring never becomes completely full.

Beat length is 8 on non-last beats and popcount(tkeep) on the tlast beat. `byte_cnt` is LEN_WIDTH+1 bits wide and does not wrap before the oversize check.

State machine:
- IDLE
  - tready=1.
  - On an accepted beat: `frame_start <= wr_ptr`, then process the beat as in RECV.
- RECV
  - tready=1.
  - For each accepted beat, compute the new count = `byte_cnt` + beat length.
  - If free space = 0, or the new count > MAX_FRAME_BYTES: do not write, enter DROP (or take the DROP exit immediately if the beat has tlast).
  - Otherwise write the beat to `wr_ptr`, then `wr_ptr++` (wraps modulo 2^ADDR_WIDTH).
  - On tlast with tuser=1: take the DROP exit.
  - On tlast with tuser=0: latch `desc_start = frame_start` and `desc_len` = new count, then go to DESC.
- DROP
  - tready=1. Accepted beats are discarded.
  - DROP exit, taken on tlast: `wr_ptr <= frame_start`, `byte_cnt <= 0`, `drop_count++` (saturating), then go to IDLE.
- DESC
  - tready=0 and desc_valid=1.
  - desc_start and desc_len stay stable until `desc_valid && desc_ready`.
  - After that handshake: `byte_cnt <= 0`, go to IDLE.

Other rules:
- A single-beat frame goes IDLE→DESC directly.
- `buf_rd_ptr` may change at any time. It is sampled every cycle for the space check.
- Frames may wrap across the ring end. The consumer handles the wrap.

## Timing
- Reset values: tready=0, buf_wr_en=0, buf_wr_addr=0, buf_wr_data=0, buf_wr_strb=0, desc_valid=0, desc_start=0, desc_len=0, drop_count=0. wr_ptr, frame_start and byte_cnt are also 0. The state is IDLE.
- tready goes to 1 on the first clock edge after resetn deasserts.
- The RAM write port is registered: a beat accepted at edge N gives buf_wr_en=1 with its address, data and strobe during cycle N+1.
- The tlast beat accepted at edge N gives desc_valid=1 from N+1. The write of that last beat is visible to the RAM no later than the cycle in which desc_valid rises.
- Every frame costs at least one tready=0 cycle (DESC).
- Reset asserted mid-frame or mid-descriptor clears everything asynchronously; the pending descriptor is lost. After release, the first accepted beat starts a new frame, even if it is the tail of an earlier frame.

## Test plan
- 64-byte frame (8 beats, tkeep=0xFF), ring empty, rd_ptr=0 -> writes at addresses 0..7, desc_start=0, desc_len=64, desc_valid one cycle after the tlast beat.
- 61-byte frame, last tkeep=0x1F, starting at wr_ptr=8 -> last strobe 0x1F, desc_start=8, desc_len=61, next frame starts at 16.
- tuser=1 on tlast of a 128-byte frame -> no descriptor, drop_count=1, next good frame gets desc_start equal to the dropped frame's start.
- wr_ptr=4092, rd_ptr=100, 64-byte frame -> writes at 4092..4095 then 0..3, desc_start=4092, desc_len=64. Repeat with rd_ptr=4095 -> dropped once the ring is full, wr_ptr restored to 4092, drop_count incremented.
- 9224-byte frame (1153 beats) -> dropped, drop_count+1, no descriptor. A following 9216-byte frame is accepted with desc_len=9216.
- desc_ready held low 20 cycles after desc_valid -> tready=0 throughout, descriptor stable, no beats lost. Separately, resetn pulsed low mid-frame -> all outputs return to their reset values immediately.
